eq_coeff_bank: RTL and testbench

Coefficient store that answers the equalizer's coefficient read requests. It acts as the responder for the equalizer's eq_coeff_addr/eq_coeff read interface.
- Double-buffered: the host streams a complete coefficient set into a shadow bank, then the banks swap atomically at an equalizer-safe boundary.
- Replaces the ad-hoc per-bench coefficient selection multiplexers.

---
 rtl/eq_coeff_bank_pkg.sv | 31 +++
 rtl/eq_coeff_bank_if.sv | 26 ++
 rtl/eq_coeff_bank_dpram.sv | 65 ++++++
 rtl/eq_coeff_bank.sv | 169 ++++++++++++++++
 tb/tb_eq_coeff_bank.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/eq_coeff_bank_pkg.sv
// eq_coeff_bank shared types, constants and helper functions.
// Used by the coefficient store, its RAM and its write-stream interface.
package eq_pkg;

    localparam int NR_EQ_BAND_COEFF = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } eq_load_state_t;

    // Source of the registered equalizer read data.
    typedef enum logic [1:0] {
        RD_ZERO,
        RD_UNITY,
        RD_RAM
    } eq_rd_sel_t;

    // Unity gain in Q3.(W-4).
    function automatic logic [63:0] eq_unity_coeff(input int width);
        return 64'd1 << (width - 4);
    endfunction

    function automatic int eq_coeff_addr_width(input int ch, input int bands);
        int n;
        n = ch * bands * NR_EQ_BAND_COEFF;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eq_coeff_bank_if.sv
// Coefficient write stream (host -> coefficient bank).
// master: wr_tdata/wr_tvalid/wr_tlast out, wr_tready in; slave: mirrored.
interface eq_coeff_bank_if #(
    parameter int EQ_COEFF_WIDTH = 32
);

    logic [EQ_COEFF_WIDTH-1:0] wr_tdata;
    logic                      wr_tvalid;
    logic                      wr_tlast;
    logic                      wr_tready;

    modport master (
        output wr_tdata,
        output wr_tvalid,
        output wr_tlast,
        input  wr_tready
    );

    modport slave (
        input  wr_tdata,
        input  wr_tvalid,
        input  wr_tlast,
        output wr_tready
    );

endinterface

// File: rtl/eq_coeff_bank_dpram.sv
// eq_coeff_dpram: two banks of DEPTH words, one write port, registered reads.
// Ports: we/wr_bank/wr_addr/wr_data, rd_bank/rd_addr -> rd_data (+ rb_* readback).
module eq_coeff_dpram #(
    parameter int DEPTH = 120,
    parameter int AW    = 7,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
`ifdef EQ_COEFF_READBACK_EN
    input  logic          rb_bank,
    input  logic [AW-1:0] rb_addr,
    output logic [W-1:0]  rb_data,
`endif
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [W-1:0] mem [2][DEPTH];

    logic [AW-1:0] rd_idx;
    logic [W-1:0]  rd_data_d;
    logic [W-1:0]  rd_data_q;

    always_ff @(posedge clk) begin
        if (we && ({1'b0, wr_addr} < DEPTH_W)) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_idx    = ({1'b0, rd_addr} < DEPTH_W) ? rd_addr : '0;
        rd_data_d = mem[rd_bank][rd_idx];
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

`ifdef EQ_COEFF_READBACK_EN
    logic [AW-1:0] rb_idx;
    logic [W-1:0]  rb_data_d;
    logic [W-1:0]  rb_data_q;

    always_comb begin
        rb_idx    = ({1'b0, rb_addr} < DEPTH_W) ? rb_addr : '0;
        rb_data_d = mem[rb_bank][rb_idx];
    end

    always_ff @(posedge clk) begin
        rb_data_q <= rb_data_d;
    end

    assign rb_data = rb_data_q;
`endif

endmodule

// File: rtl/eq_coeff_bank.sv
// eq_coeff_bank: double-buffered equalizer coefficient store with atomic swap.
// Ports: clk, rst_n, eq_coeff_addr -> eq_coeff (1-cycle), wr (write stream),
// swap_en, pending, bank_sel, load_error; rd_addr/rd_data shadow readback
// only when EQ_COEFF_READBACK_EN is defined.
module eq_coeff_bank
    import eq_pkg::*;
#(
    parameter int NR_CHANNELS    = 3,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32,
    localparam int NR_EQ_COEFF   = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
    localparam int EQ_COEFF_ADDR_WIDTH = eq_coeff_addr_width(NR_CHANNELS, NR_EQ_BANDS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [EQ_COEFF_ADDR_WIDTH-1:0] eq_coeff_addr,
    output logic [EQ_COEFF_WIDTH-1:0]      eq_coeff,
    eq_coeff_bank_if.slave                 wr,
`ifdef EQ_COEFF_READBACK_EN
    input  logic [EQ_COEFF_ADDR_WIDTH-1:0] rd_addr,
    output logic [EQ_COEFF_WIDTH-1:0]      rd_data,
`endif
    input  logic                           swap_en,
    output logic                           pending,
    output logic                           bank_sel,
    output logic                           load_error
);

    localparam int AW = EQ_COEFF_ADDR_WIDTH;
    localparam int CW = AW + 1;
    localparam int W  = EQ_COEFF_WIDTH;

    localparam logic [W-1:0]  UNITY    = W'(eq_unity_coeff(W));
    localparam logic [CW-1:0] NR_W     = CW'(NR_EQ_COEFF);
    localparam logic [CW-1:0] LAST_IDX = CW'(NR_EQ_COEFF - 1);
    localparam logic [AW-1:0] BAND_MOD = AW'(NR_EQ_BAND_COEFF);

    eq_load_state_t state_q, state_d;
    eq_rd_sel_t     rd_sel_q, rd_sel_d;

    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          bank_sel_q, bank_sel_d;
    logic          set_valid_q, set_valid_d;
    logic          wr_tready_q, wr_tready_d;
    logic          pending_q, pending_d;
    logic          load_error_q, load_error_d;

    logic          accept;
    logic          in_range;
    logic [W-1:0]  ram_rd_data;

    assign accept = wr.wr_tvalid & wr_tready_q;

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        bank_sel_d   = bank_sel_q;
        set_valid_d  = set_valid_q;
        load_error_d = 1'b0;

        unique case (state_q)
            IDLE, LOAD: begin
                // wr_cnt is 0 in IDLE, so both states share the beat rules.
                if (accept) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        if (wr.wr_tlast) begin
                            state_d = PENDING;
                        end else begin
                            state_d      = IDLE;
                            load_error_d = 1'b1;
                        end
                    end else if (wr.wr_tlast) begin
                        state_d      = IDLE;
                        wr_cnt_d     = '0;
                        load_error_d = 1'b1;
                    end else begin
                        state_d  = LOAD;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            PENDING: begin
                if (swap_en) begin
                    state_d     = IDLE;
                    bank_sel_d  = ~bank_sel_q;
                    set_valid_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_cnt_d = '0;
            end
        endcase

        wr_tready_d = (state_d != PENDING);
        pending_d   = (state_d == PENDING);
    end

    // Read source is decided with the bank state of the capturing edge,
    // so a read in flight at a swap completes from the old bank.
    always_comb begin
        in_range = ({1'b0, eq_coeff_addr} < NR_W);
        rd_sel_d = RD_ZERO;
        if (in_range) begin
            if (set_valid_q) begin
                rd_sel_d = RD_RAM;
            end else if ((eq_coeff_addr % BAND_MOD) == '0) begin
                rd_sel_d = RD_UNITY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_sel_q     <= RD_ZERO;
            wr_cnt_q     <= '0;
            bank_sel_q   <= 1'b0;
            set_valid_q  <= 1'b0;
            wr_tready_q  <= 1'b0;
            pending_q    <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_sel_q     <= rd_sel_d;
            wr_cnt_q     <= wr_cnt_d;
            bank_sel_q   <= bank_sel_d;
            set_valid_q  <= set_valid_d;
            wr_tready_q  <= wr_tready_d;
            pending_q    <= pending_d;
            load_error_q <= load_error_d;
        end
    end

    eq_coeff_dpram #(
        .DEPTH (NR_EQ_COEFF),
        .AW    (AW),
        .W     (W)
    ) u_dpram (
        .clk     (clk),
        .we      (accept),
        .wr_bank (~bank_sel_q),
        .wr_addr (wr_cnt_q[AW-1:0]),
        .wr_data (wr.wr_tdata),
`ifdef EQ_COEFF_READBACK_EN
        .rb_bank (~bank_sel_q),
        .rb_addr (rd_addr),
        .rb_data (rd_data),
`endif
        .rd_bank (bank_sel_q),
        .rd_addr (eq_coeff_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        unique case (rd_sel_q)
            RD_RAM:   eq_coeff = ram_rd_data;
            RD_UNITY: eq_coeff = UNITY;
            default:  eq_coeff = '0;
        endcase
    end

    assign wr.wr_tready = wr_tready_q;
    assign pending      = pending_q;
    assign bank_sel     = bank_sel_q;
    assign load_error   = load_error_q;

endmodule

// File: tb/tb_eq_coeff_bank.sv
// tb_eq_coeff_bank: scoreboard bench for eq_coeff_bank.
// Reads push expected data to a queue; compared one cycle later.
module tb_eq_coeff_bank;

    localparam int AW = 7;
    localparam int W  = 32;
    localparam logic [W-1:0] UNITY = 32'h1000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] eq_coeff_addr;
    logic [W-1:0]  eq_coeff;
    logic          swap_en;
    logic          pending;
    logic          bank_sel;
    logic          load_error;
`ifdef EQ_COEFF_READBACK_EN
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
`endif

    eq_coeff_bank_if #(.EQ_COEFF_WIDTH(W)) wr_if ();

    eq_coeff_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .eq_coeff_addr (eq_coeff_addr),
        .eq_coeff      (eq_coeff),
        .wr            (wr_if),
`ifdef EQ_COEFF_READBACK_EN
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
`endif
        .swap_en       (swap_en),
        .pending       (pending),
        .bank_sel      (bank_sel),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int e0;
    logic [W-1:0] sb [$];

    always @(negedge clk) begin
        if (load_error) err_cnt++;
    end

    task automatic check(input string tag, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e);
        @(negedge clk);
        eq_coeff_addr = a;
        sb.push_back(e);
        @(negedge clk);
        check($sformatf("rd[%0d]", a), eq_coeff, sb.pop_front());
    endtask

    task automatic swap();
        @(negedge clk);
        swap_en = 1'b1;
        @(negedge clk);
        swap_en = 1'b0;
    endtask

    task automatic send_set(input int n, input int last_at, input int base,
                            input bit swap_last, input int abort_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) check("wr_tready", {31'b0, wr_if.wr_tready}, 32'd1);
            wr_if.wr_tvalid = 1'b1;
            wr_if.wr_tdata  = W'(base + i);
            wr_if.wr_tlast  = (i == last_at);
            swap_en         = swap_last && (i == n - 1);
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                return;
            end
        end
        @(negedge clk);
        wr_if.wr_tvalid = 1'b0;
        wr_if.wr_tlast  = 1'b0;
        swap_en         = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_eq_coeff"}, eq_coeff, '0);
        check({tag, "_tready"}, {31'b0, wr_if.wr_tready}, 32'd0);
        check({tag, "_pending"}, {31'b0, pending}, 32'd0);
        check({tag, "_bank_sel"}, {31'b0, bank_sel}, 32'd0);
        check({tag, "_load_error"}, {31'b0, load_error}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        eq_coeff_addr   = '0;
        swap_en         = 1'b0;
        wr_if.wr_tdata  = '0;
        wr_if.wr_tvalid = 1'b0;
        wr_if.wr_tlast  = 1'b0;
`ifdef EQ_COEFF_READBACK_EN
        rd_addr = '0;
`endif
        repeat (2) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;

        // 1: unity passthrough before any set is loaded
        rd(7'd0, UNITY);
        rd(7'd1, '0);
        rd(7'd5, UNITY);
        rd(7'd119, '0);
        rd(7'd125, '0);
        check("t1_bank_sel", {31'b0, bank_sel}, 32'd0);

        // 2: full load then swap
        e0 = err_cnt;
        send_set(120, 119, 0, 1'b0, -1);
        check("t2_pending", {31'b0, pending}, 32'd1);
        check("t2_tready", {31'b0, wr_if.wr_tready}, 32'd0);
        check("t2_bank_pre", {31'b0, bank_sel}, 32'd0);
        swap();
        check("t2_pending_post", {31'b0, pending}, 32'd0);
        check("t2_bank_sel", {31'b0, bank_sel}, 32'd1);
        check("t2_err", W'(err_cnt - e0), 32'd0);
        rd(7'd42, 32'd42);
        rd(7'd0, 32'd0);
        rd(7'd119, 32'd119);
        rd(7'd120, '0);

        // 3: early tlast
        e0 = err_cnt;
        send_set(51, 50, 500, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("t3_err", W'(err_cnt - e0), 32'd1);
        check("t3_pending", {31'b0, pending}, 32'd0);
        check("t3_tready", {31'b0, wr_if.wr_tready}, 32'd1);
        check("t3_bank_sel", {31'b0, bank_sel}, 32'd1);
        rd(7'd42, 32'd42);

        // 4: missing tlast, then restart at index 0
        e0 = err_cnt;
        send_set(120, -1, 700, 1'b0, -1);
        repeat (2) @(negedge clk);
        check("t4_err", W'(err_cnt - e0), 32'd1);
        check("t4_pending", {31'b0, pending}, 32'd0);
        send_set(120, 119, 1000, 1'b0, -1);
        check("t4_pending_ok", {31'b0, pending}, 32'd1);
        check("t4_err_after", W'(err_cnt - e0), 32'd1);
        swap();
        check("t4_bank_sel", {31'b0, bank_sel}, 32'd0);
        rd(7'd0, 32'd1000);
        rd(7'd119, 32'd1119);
        rd(7'd42, 32'd1042);

        // 5: swap_en on the final beat is ignored
        send_set(120, 119, 2000, 1'b1, -1);
        check("t5_pending", {31'b0, pending}, 32'd1);
        check("t5_bank_pre", {31'b0, bank_sel}, 32'd0);
        repeat (10) @(negedge clk);
        check("t5_pending_wait", {31'b0, pending}, 32'd1);
        rd(7'd7, 32'd1007);
        swap();
        check("t5_bank_sel", {31'b0, bank_sel}, 32'd1);
        check("t5_pending_post", {31'b0, pending}, 32'd0);
        rd(7'd7, 32'd2007);

        // 6: async reset mid-load
        send_set(120, 119, 3000, 1'b0, 60);
        #1;
        check_reset_outs("t6");
        wr_if.wr_tvalid = 1'b0;
        wr_if.wr_tlast  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(7'd10, UNITY);
        rd(7'd3, '0);
        send_set(120, 119, 3000, 1'b0, -1);
        check("t6_pending", {31'b0, pending}, 32'd1);
        swap();
        check("t6_bank_sel", {31'b0, bank_sel}, 32'd1);
        rd(7'd119, 32'd3119);
        rd(7'd60, 32'd3060);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
